// File: rtl/pma_seq_checker.sv
// pma_seq_checker: multi-cycle PMA classifier scanning RULES_PER_CYCLE rules per class per cycle.
// Define PMA_SEQ_EARLY_EXIT_EN to leave the scan as soon as no remaining rule can change the flags.
module pma_seq_checker #(
   parameter int NR_MAX_RULES    = 16,
   parameter int RULES_PER_CYCLE = 4,
   parameter int ADDR_W          = 64
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           flush_i,
   input  logic                           req_valid_i,
   output logic                           req_ready_o,
   input  logic [ADDR_W-1:0]              req_addr_i,
   input  logic [4:0]                     nr_nonidem_i,
   input  logic [NR_MAX_RULES*ADDR_W-1:0] nonidem_base_i,
   input  logic [NR_MAX_RULES*ADDR_W-1:0] nonidem_len_i,
   input  logic [4:0]                     nr_exec_i,
   input  logic [NR_MAX_RULES*ADDR_W-1:0] exec_base_i,
   input  logic [NR_MAX_RULES*ADDR_W-1:0] exec_len_i,
   input  logic [4:0]                     nr_cached_i,
   input  logic [NR_MAX_RULES*ADDR_W-1:0] cached_base_i,
   input  logic [NR_MAX_RULES*ADDR_W-1:0] cached_len_i,
   output logic                           rsp_valid_o,
   input  logic                           rsp_ready_i,
   output logic                           rsp_nonidem_o,
   output logic                           rsp_exec_o,
   output logic                           rsp_cached_o
);
   localparam int SelW = (NR_MAX_RULES > 1) ? $clog2(NR_MAX_RULES) : 1;
   localparam logic [4:0] MaxCnt = 5'(NR_MAX_RULES);
   localparam logic [4:0] Step = 5'(RULES_PER_CYCLE);

   typedef enum logic [1:0] {IDLE, SCAN, RESP} stateT;

   stateT state;
   logic [ADDR_W-1:0] reqAddr;
   logic [4:0] cntNonidem, cntExec, cntCached, reqLimit, scanLimit, idx, nextIdx;
   logic [2:0] accum, accNext;
   logic [RULES_PER_CYCLE-1:0] laneNonidem, laneExec, laneCached;
   logic lastBeat, scanDone;

   function automatic logic [4:0] satCount(input logic [4:0] n);
      return (n > MaxCnt) ? MaxCnt : n;
   endfunction

   // The end of the region is formed one bit wider so a region touching the top of memory cannot wrap.
   function automatic logic ruleHit(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l);
      return (a >= b) && ({1'b0, a} < ({1'b0, b} + {1'b0, l}));
   endfunction

   assign cntNonidem = satCount(nr_nonidem_i);
   assign cntExec    = satCount(nr_exec_i);
   assign cntCached  = satCount(nr_cached_i);
   assign reqLimit   = (cntNonidem > cntExec) ? ((cntNonidem > cntCached) ? cntNonidem : cntCached)
                                              : ((cntExec > cntCached) ? cntExec : cntCached);

   for (genvar i = 0; i < RULES_PER_CYCLE; i++) begin : g_lane
      logic [4:0] j;
      logic [SelW-1:0] sel;
      assign j   = idx + 5'(i);
      assign sel = j[SelW-1:0];
      assign laneNonidem[i] = (j < cntNonidem) && ruleHit(reqAddr, nonidem_base_i[sel*ADDR_W +: ADDR_W], nonidem_len_i[sel*ADDR_W +: ADDR_W]);
      assign laneExec[i]    = (j < cntExec)    && ruleHit(reqAddr, exec_base_i[sel*ADDR_W +: ADDR_W], exec_len_i[sel*ADDR_W +: ADDR_W]);
      assign laneCached[i]  = (j < cntCached)  && ruleHit(reqAddr, cached_base_i[sel*ADDR_W +: ADDR_W], cached_len_i[sel*ADDR_W +: ADDR_W]);
   end

   assign accNext  = accum | {|laneCached, |laneExec, |laneNonidem};
   assign nextIdx  = idx + Step;
   assign lastBeat = nextIdx >= scanLimit;

`ifdef PMA_SEQ_EARLY_EXIT_EN
   logic [2:0] remaining;
   assign remaining = {nextIdx < cntCached, nextIdx < cntExec, nextIdx < cntNonidem};
   assign scanDone  = lastBeat || (&(accNext | ~remaining));
`else
   assign scanDone  = lastBeat;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         req_ready_o   <= 1'b1;
         rsp_valid_o   <= 1'b0;
         rsp_nonidem_o <= 1'b0;
         rsp_exec_o    <= 1'b0;
         rsp_cached_o  <= 1'b0;
         reqAddr       <= '0;
         scanLimit     <= '0;
         idx           <= '0;
         accum         <= '0;
      end else if (flush_i) begin
         state       <= IDLE;
         req_ready_o <= 1'b1;
         rsp_valid_o <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid_i && req_ready_o) begin
               reqAddr     <= req_addr_i;
               scanLimit   <= reqLimit;
               accum       <= '0;
               idx         <= '0;
               req_ready_o <= 1'b0;
               if (reqLimit == 5'd0) begin
                  state         <= RESP;
                  rsp_valid_o   <= 1'b1;
                  rsp_nonidem_o <= 1'b0;
                  rsp_exec_o    <= 1'b1;
                  rsp_cached_o  <= 1'b0;
               end else begin
                  state <= SCAN;
               end
            end
            SCAN: begin
               accum <= accNext;
               idx   <= nextIdx;
               if (scanDone) begin
                  state         <= RESP;
                  rsp_valid_o   <= 1'b1;
                  rsp_nonidem_o <= accNext[0];
                  rsp_exec_o    <= (cntExec == 5'd0) || accNext[1];
                  rsp_cached_o  <= accNext[2];
               end
            end
            RESP: if (rsp_ready_i) begin
               state       <= IDLE;
               rsp_valid_o <= 1'b0;
               req_ready_o <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pma_seq_checker.sv
// tb_pma_seq_checker: vector table, hand-written corner sequences and randomized lookups against a reference model.
module tb_pma_seq_checker;
   logic clk_i = 1'b0, rst_i = 1'b1, flush_i = 1'b0, req_valid_i = 1'b0, rsp_ready_i = 1'b0;
   logic req_ready_o, rsp_valid_o, rsp_nonidem_o, rsp_exec_o, rsp_cached_o;
   logic [63:0] req_addr_i = '0;
   logic [4:0] nr_nonidem_i = '0, nr_exec_i = '0, nr_cached_i = '0;
   logic [15:0][63:0] nb, nl, eb, el, cb, cl;
   int checks = 0, failures = 0;

   typedef struct {
      logic [63:0] addr;
      logic [4:0] rN, rE, rC;
      logic [2:0] flags;
      int latFixed, latEarly;
   } vecT;
   vecT vecs[12];

   pma_seq_checker dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
      .nr_nonidem_i(nr_nonidem_i), .nonidem_base_i(nb), .nonidem_len_i(nl),
      .nr_exec_i(nr_exec_i), .exec_base_i(eb), .exec_len_i(el),
      .nr_cached_i(nr_cached_i), .cached_base_i(cb), .cached_len_i(cl),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_nonidem_o(rsp_nonidem_o), .rsp_exec_o(rsp_exec_o), .rsp_cached_o(rsp_cached_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Offset form of the region test: inside iff the address is past the base by less than the length.
   function automatic logic inRange(input logic [63:0] a, input logic [63:0] b, input logic [63:0] l);
      return (a >= b) && ((a - b) < l);
   endfunction

   function automatic logic classHit(input int cls, input logic [63:0] a, input int upto);
      logic [63:0] b, l;
      for (int k = 0; k < upto; k++) begin
         b = (cls == 0) ? nb[k] : (cls == 1) ? eb[k] : cb[k];
         l = (cls == 0) ? nl[k] : (cls == 1) ? el[k] : cl[k];
         if (inRange(a, b, l)) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic int satInt(input logic [4:0] n);
      return (int'(n) > 16) ? 16 : int'(n);
   endfunction

   task automatic model(input logic [63:0] a, input logic [4:0] rN, input logic [4:0] rE, input logic [4:0] rC,
                        output logic [2:0] f, output int lat);
      int cN, cE, cC, lim, beats;
      cN = satInt(rN);
      cE = satInt(rE);
      cC = satInt(rC);
      lim = (cN > cE) ? cN : cE;
      lim = (lim > cC) ? lim : cC;
      beats = (lim + 3) / 4;
      f = {classHit(0, a, cN), (cE == 0) || classHit(1, a, cE), classHit(2, a, cC)};
      lat = 1 + beats;
`ifdef PMA_SEQ_EARLY_EXIT_EN
      begin
         bit found = 0;
         for (int c = 1; c <= beats && !found; c++) begin
            if ((4*c >= cN || classHit(0, a, 4*c)) && (4*c >= cE || classHit(1, a, 4*c)) && (4*c >= cC || classHit(2, a, 4*c))) begin
               lat = 1 + c;
               found = 1;
            end
         end
      end
`endif
   endtask

   task automatic doLookup(input string name, input logic [63:0] a, input logic [4:0] rN, input logic [4:0] rE,
                           input logic [4:0] rC, input int hold, input logic [2:0] expF, input int expLat);
      int lat;
      req_addr_i = a;
      nr_nonidem_i = rN;
      nr_exec_i = rE;
      nr_cached_i = rC;
      req_valid_i = 1'b1;
      tick();
      req_valid_i = 1'b0;
      lat = 1;
      while (!rsp_valid_o && lat < 40) begin
         tick();
         lat++;
      end
      check({name, " latency"}, 64'(lat), 64'(expLat));
      if (!rsp_valid_o) begin
         flush_i = 1'b1;
         tick();
         flush_i = 1'b0;
         return;
      end
      check({name, " flags"}, 64'({req_ready_o, rsp_nonidem_o, rsp_exec_o, rsp_cached_o}), 64'({1'b0, expF}));
      for (int i = 0; i < hold; i++) begin
         tick();
         check({name, " hold"}, 64'({rsp_valid_o, req_ready_o, rsp_nonidem_o, rsp_exec_o, rsp_cached_o}), 64'({2'b10, expF}));
      end
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      check({name, " release"}, 64'({rsp_valid_o, req_ready_o}), 64'(2'b01));
   endtask

   initial begin
      logic [2:0] f;
      int lat, quiet;
      logic [63:0] a;
      logic [4:0] rN, rE, rC;
      nb = '0; nl = '0; eb = '0; el = '0; cb = '0; cl = '0;
      repeat (2) tick();
      rst_i = 1'b0;
      check("reset", 64'({req_ready_o, rsp_valid_o, rsp_nonidem_o, rsp_exec_o, rsp_cached_o}), 64'(5'b10000));

      nb[0] = 64'h0;         nl[0] = 64'h1000;
      eb[0] = 64'h8000_0000; el[0] = 64'h4000_0000;
      cb[0] = 64'h8000_0000; cl[0] = 64'h4000_0000;
      vecs[0]  = '{64'h8000_0000, 5'd0,  5'd0,  5'd0,  3'b010, 1, 1};
      vecs[1]  = '{64'hBFFF_FFFF, 5'd1,  5'd1,  5'd1,  3'b011, 2, 2};
      vecs[2]  = '{64'hC000_0000, 5'd1,  5'd1,  5'd1,  3'b000, 2, 2};
      vecs[3]  = '{64'h8000_0000, 5'd1,  5'd1,  5'd1,  3'b011, 2, 2};
      vecs[4]  = '{64'h7FFF_FFFF, 5'd1,  5'd1,  5'd1,  3'b000, 2, 2};
      vecs[5]  = '{64'h0,         5'd1,  5'd1,  5'd1,  3'b100, 2, 2};
      vecs[6]  = '{64'hFFF,       5'd1,  5'd1,  5'd1,  3'b100, 2, 2};
      vecs[7]  = '{64'h1000,      5'd1,  5'd1,  5'd1,  3'b000, 2, 2};
      vecs[8]  = '{64'hC000_0000, 5'd1,  5'd0,  5'd1,  3'b010, 2, 2};
      vecs[9]  = '{64'h0,         5'd31, 5'd1,  5'd1,  3'b100, 5, 2};
      vecs[10] = '{64'h9000_0000, 5'd1,  5'd16, 5'd17, 3'b011, 5, 2};
      vecs[11] = '{64'h10,        5'd5,  5'd0,  5'd0,  3'b110, 3, 2};
      for (int v = 0; v < 12; v++) begin
`ifdef PMA_SEQ_EARLY_EXIT_EN
         doLookup($sformatf("vec%0d", v), vecs[v].addr, vecs[v].rN, vecs[v].rE, vecs[v].rC, v % 2, vecs[v].flags, vecs[v].latEarly);
`else
         doLookup($sformatf("vec%0d", v), vecs[v].addr, vecs[v].rN, vecs[v].rE, vecs[v].rC, v % 2, vecs[v].flags, vecs[v].latFixed);
`endif
      end

      // Only the last of 16 non-idempotent rules covers the address.
      for (int k = 0; k < 15; k++) begin
         nb[k] = 64'(k) << 12;
         nl[k] = 64'h10;
      end
      nb[15] = 64'h1_0000_0000; nl[15] = 64'h10;
      doLookup("rule15", 64'h1_0000_000F, 5'd16, 5'd0, 5'd0, 7, 3'b110, 5);
      nb[15] = 64'hFFFF_FFFF_FFFF_FFF0; nl[15] = 64'h20;
      doLookup("topwrap", 64'hFFFF_FFFF_FFFF_FFFF, 5'd16, 5'd0, 5'd0, 0, 3'b110, 5);

      req_addr_i = 64'h5_0000_0000;
      nr_nonidem_i = 5'd16; nr_exec_i = 5'd0; nr_cached_i = 5'd0;
      req_valid_i = 1'b1;
      tick();
      req_valid_i = 1'b0;
      tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      check("flush idle", 64'({rsp_valid_o, req_ready_o}), 64'(2'b01));
      quiet = 0;
      repeat (6) begin
         tick();
         quiet += int'(rsp_valid_o);
      end
      check("flush no rsp", 64'(quiet), 64'(0));
      doLookup("postflush", 64'h5_0000_0000, 5'd16, 5'd0, 5'd0, 0, 3'b010, 5);

      req_valid_i = 1'b1;
      flush_i = 1'b1;
      tick();
      req_valid_i = 1'b0;
      flush_i = 1'b0;
      check("flush blocks accept", 64'({rsp_valid_o, req_ready_o}), 64'(2'b01));
      quiet = 0;
      repeat (6) begin
         tick();
         quiet += int'(rsp_valid_o);
      end
      check("flush req no rsp", 64'(quiet), 64'(0));

      for (int n = 0; n < 150; n++) begin
         for (int k = 0; k < 16; k++) begin
            nb[k] = 64'($urandom_range(0, 255)) << 8;
            nl[k] = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(1, 1024));
            eb[k] = 64'($urandom_range(0, 255)) << 8;
            el[k] = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(1, 1024));
            cb[k] = 64'($urandom_range(0, 255)) << 8;
            cl[k] = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(1, 1024));
         end
         case ($urandom_range(0, 3))
            0: a = 64'($urandom_range(0, 70000));
            1: a = nb[$urandom_range(0, 15)] + 64'($urandom_range(0, 1100));
            2: a = eb[$urandom_range(0, 15)] + 64'($urandom_range(0, 1100));
            default: a = cb[$urandom_range(0, 15)] + 64'($urandom_range(0, 1100));
         endcase
         rN = 5'($urandom_range(0, 20));
         rE = 5'($urandom_range(0, 20));
         rC = 5'($urandom_range(0, 20));
         model(a, rN, rE, rC, f, lat);
         doLookup($sformatf("rand%0d", n), a, rN, rE, rC, $urandom_range(0, 2), f, lat);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
